errbit_frame_sched: RTL

- Sequences the shared 850-bit error-bit counter (errBit_cnt_top) across all ROW_CHUNK_NUM sub-matrix chunks of one decoded frame.
- Derives each frame's error count, then maintains BER/FER statistics and the simulation stop condition.
- Sits between the layered decoder's hard-decision output (half eval_clk rate) and the counter, in the simulation-logger BSP.

---
 rtl/errbit_logger_pkg.sv | 24 ++
 rtl/errbit_chunk_mux.sv | 20 ++
 rtl/errbit_frame_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/errbit_logger_pkg.sv
// Shared constants and FSM state type for the error-bit frame scheduler and
// the errBit_cnt_top counter it drives.
package errbit_logger_pkg;

  localparam int VN_NUM        = 7650;
  localparam int N             = 850;
  localparam int ROW_CHUNK_NUM = 9;
  localparam int CNT_WIDTH     = 13;
  localparam int EN_CYCLES     = 12;
  localparam int TIMEOUT       = 32;
  localparam int ACC_WIDTH     = 40;
  localparam int FRM_WIDTH     = 32;

  localparam int FEED_W = $clog2(EN_CYCLES);
  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT,
    UPDATE
  } sched_state_e;

endpackage

// File: rtl/errbit_chunk_mux.sv
// Picks one N-bit chunk of a frame by index; out-of-range indices yield
// all-ones, which the counter sees as a chunk with zero bit errors.
module errbit_chunk_mux #(
  parameter int N             = 850,
  parameter int ROW_CHUNK_NUM = 9,
  parameter int SEL_W         = 4
) (
  input  logic [N*ROW_CHUNK_NUM-1:0] frame,
  input  logic [SEL_W-1:0]           sel,
  output logic [N-1:0]               chunk
);

  always_comb begin
    chunk = '1;
    for (int i = 0; i < ROW_CHUNK_NUM; i++) begin
      if (sel == SEL_W'(i)) chunk = frame[i*N +: N];
    end
  end

endmodule

// File: rtl/errbit_frame_sched.sv
// Feeds one decoded frame chunk-by-chunk into the shared error-bit counter,
// derives the per-frame error count and keeps BER/FER totals and the stop flag.
module errbit_frame_sched
  import errbit_logger_pkg::*;
#(
  parameter logic [FRM_WIDTH-1:0] MAX_FRAMES    = 32'd1000000,
  parameter logic [FRM_WIDTH-1:0] MAX_FRAME_ERR = 32'd100
) (
  input  logic                 eval_clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 start,
  input  logic [VN_NUM-1:0]    hard_decision,
  output logic                 ready,
  output logic [N-1:0]         cnt_hard_frame,
  output logic                 cnt_en,
  input  logic [CNT_WIDTH-1:0] cnt_err_count,
  input  logic                 cnt_count_done,
  output logic [CNT_WIDTH-1:0] frame_err,
  output logic                 frame_valid,
  output logic [ACC_WIDTH-1:0] total_bit_err,
  output logic [FRM_WIDTH-1:0] total_frame_err,
  output logic [FRM_WIDTH-1:0] frame_num,
  output logic                 sim_done,
  output logic                 timeout_err
);

  sched_state_e         state_q, state_d;
  logic                 start_q, start_qd;
  logic [VN_NUM-1:0]    frame_reg;
  logic [FEED_W-1:0]    feed_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0] snapshot;
  logic                 clr_pend;
  logic [N-1:0]         mux_chunk;
  logic                 start_edge, do_clear, accept, timeout_hit;
  logic [CNT_WIDTH-1:0] fe_new;
  logic [ACC_WIDTH:0]   bit_sum;

  errbit_chunk_mux #(
    .N             (N),
    .ROW_CHUNK_NUM (ROW_CHUNK_NUM),
    .SEL_W         (FEED_W)
  ) u_chunk_mux (
    .frame (frame_reg),
    .sel   (feed_cnt),
    .chunk (mux_chunk)
  );

  assign start_edge = start_q & ~start_qd;
  assign do_clear   = (state_q == IDLE) && (clear || clr_pend);
  // The frame_valid cycle is held off too, so a start cannot slip in before sim_done settles.
  assign accept     = (state_q == IDLE) && start_edge && !sim_done && !frame_valid && !do_clear;

  assign cnt_hard_frame = (state_q == FEED) ? mux_chunk : '1;

  // Counter total never self-clears, so the difference wraps modulo 2^CNT_WIDTH.
  assign fe_new  = cnt_err_count - snapshot;
  assign bit_sum = {1'b0, total_bit_err} + {{(ACC_WIDTH + 1 - CNT_WIDTH){1'b0}}, fe_new};

  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    cnt_en      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        ready = !sim_done && !frame_valid;
        if (accept) state_d = FEED;
      end
      FEED: begin
        cnt_en = 1'b1;
        if (feed_cnt == FEED_W'(EN_CYCLES - 1)) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_count_done) begin
          state_d = UPDATE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      start_q         <= 1'b0;
      start_qd        <= 1'b0;
      frame_reg       <= '0;
      feed_cnt        <= '0;
      wait_cnt        <= '0;
      snapshot        <= '0;
      clr_pend        <= 1'b0;
      frame_err       <= '0;
      frame_valid     <= 1'b0;
      total_bit_err   <= '0;
      total_frame_err <= '0;
      frame_num       <= '0;
      sim_done        <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      start_q     <= start;
      start_qd    <= start_q;
      feed_cnt    <= (state_q == FEED) ? feed_cnt + FEED_W'(1) : '0;
      wait_cnt    <= (state_q == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      frame_valid <= (state_q == UPDATE);

      if (accept) frame_reg <= hard_decision;

      if (state_q == UPDATE) begin
        frame_err     <= fe_new;
        snapshot      <= cnt_err_count;
        total_bit_err <= bit_sum[ACC_WIDTH] ? '1 : bit_sum[ACC_WIDTH-1:0];
        if (fe_new != '0 && total_frame_err != '1)
          total_frame_err <= total_frame_err + FRM_WIDTH'(1);
        if (frame_num != '1)
          frame_num <= frame_num + FRM_WIDTH'(1);
      end

      if (timeout_hit) timeout_err <= 1'b1;

      if (frame_valid && (frame_num >= MAX_FRAMES || total_frame_err >= MAX_FRAME_ERR))
        sim_done <= 1'b1;

      if (clear && state_q != IDLE) clr_pend <= 1'b1;

      // Snapshot is deliberately kept: it tracks the counter, not the statistics.
      if (do_clear) begin
        clr_pend        <= 1'b0;
        total_bit_err   <= '0;
        total_frame_err <= '0;
        frame_num       <= '0;
        sim_done        <= 1'b0;
        timeout_err     <= 1'b0;
      end
    end
  end

endmodule
